// File: rtl/frame_threshold_pkg.sv
// Shared encodings and the pixel transform for the frame threshold buffer.
package frame_threshold_pkg;

   typedef enum logic [1:0] {
      ST_WRITE = 2'b00,
      ST_CALC  = 2'b01,
      ST_READ  = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   localparam logic [1:0] MODE_PASS    = 2'b00;
   localparam logic [1:0] MODE_THR     = 2'b01;
   localparam logic [1:0] MODE_INV     = 2'b10;
   localparam logic [1:0] MODE_THR_INV = 2'b11;

   localparam int unsigned MAX_PIX_W = 32;

   // Operates on zero-extended values; pix_w sets the width of "all-ones".
   function automatic logic [MAX_PIX_W-1:0] pixel_f(input logic [MAX_PIX_W-1:0] p,
                                                    input logic [MAX_PIX_W-1:0] mean,
                                                    input logic [1:0]           mode,
                                                    input int unsigned          pix_w);
      logic [MAX_PIX_W-1:0] ones;
      logic [MAX_PIX_W-1:0] r;
      logic                 gt;
      ones = (pix_w >= MAX_PIX_W) ? '1 : ((MAX_PIX_W'(1) << pix_w) - MAX_PIX_W'(1));
      gt   = p > mean;
      r    = '0;
      case (mode)
         MODE_PASS:    r = p;
         MODE_THR:     r = gt ? ones : '0;
         MODE_INV:     r = ~p & ones;
         MODE_THR_INV: r = gt ? '0 : ones;
         default:      r = p;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store with a registered read port.
module frame_ram #(
   parameter int unsigned AW    = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] din,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] dout
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= din;
      if (re) dout <= mem[raddr];
   end

endmodule

// File: rtl/frame_threshold_buffer.sv
// Captures one frame from the UART stream, computes its mean, then replays it
// through a selectable pixel transform.
module frame_threshold_buffer
   import frame_threshold_pkg::*;
#(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned LOG2_W = 6,
   parameter int unsigned LOG2_H = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_rx,
   input  logic [PIX_W-1:0] data_rx,
   input  logic [1:0]       mode,
   input  logic             ready_tx,
   output logic [PIX_W-1:0] data_out,
   output logic             data_valid,
   output logic [1:0]       state,
   output logic [PIX_W-1:0] mean_out,
   output logic             frame_done,
   output logic             overrun
);

   localparam int unsigned AW    = LOG2_W + LOG2_H;
   localparam int unsigned SUM_W = PIX_W + AW;

   state_e               state_q, state_d;
   logic [AW-1:0]        wr_addr_q, wr_addr_d;
   logic [AW:0]          rd_addr_q, rd_addr_d;  // extra bit marks "all reads issued"
   logic [AW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [SUM_W-1:0]     sum_q, sum_d;
   logic [1:0]           mode_q, mode_d;
   logic                 inflight_q, inflight_d;
   logic [PIX_W-1:0]     data_out_q, data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic [PIX_W-1:0]     mean_q, mean_d;
   logic                 overrun_q, overrun_d;

   logic                 ram_we, ram_re, xfer;
   logic [PIX_W-1:0]     ram_dout;
   logic [MAX_PIX_W-1:0] xf_wide;

   frame_ram #(
      .AW    (AW),
      .WIDTH (PIX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_addr_q),
      .din   (data_rx),
      .re    (ram_re),
      .raddr (rd_addr_q[AW-1:0]),
      .dout  (ram_dout)
   );

   assign xf_wide = pixel_f(MAX_PIX_W'(ram_dout), MAX_PIX_W'(mean_q), mode_q, PIX_W);

   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      rd_addr_d    = rd_addr_q;
      tx_cnt_d     = tx_cnt_q;
      sum_d        = sum_q;
      mode_d       = mode_q;
      inflight_d   = 1'b0;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      mean_d       = mean_q;
      overrun_d    = overrun_q | (valid_rx && (state_q != ST_WRITE));
      ram_we       = 1'b0;
      ram_re       = 1'b0;
      xfer         = data_valid_q && ready_tx;

      unique case (state_q)
         ST_WRITE: begin
            if (valid_rx) begin
               ram_we    = 1'b1;
               wr_addr_d = wr_addr_q + AW'(1);
               sum_d     = sum_q + SUM_W'(data_rx);
               if (&wr_addr_q) state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            mean_d  = sum_q[SUM_W-1:AW];
            mode_d  = mode;
            state_d = ST_READ;
         end
         ST_READ: begin
            if (!rd_addr_q[AW] && !inflight_q && (!data_valid_q || ready_tx)) begin
               ram_re    = 1'b1;
               rd_addr_d = rd_addr_q + (AW+1)'(1);
            end
            inflight_d = ram_re;
            if (inflight_q) begin
               data_out_d   = xf_wide[PIX_W-1:0];
               data_valid_d = 1'b1;
            end else if (xfer) begin
               data_valid_d = 1'b0;
            end
            if (xfer) begin
               tx_cnt_d = tx_cnt_q + AW'(1);
               if (&tx_cnt_q) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            wr_addr_d    = '0;
            rd_addr_d    = '0;
            tx_cnt_d     = '0;
            sum_d        = '0;
            data_valid_d = 1'b0;
            state_d      = ST_WRITE;
         end
         default: state_d = ST_WRITE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_WRITE;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         tx_cnt_q     <= '0;
         sum_q        <= '0;
         mode_q       <= MODE_PASS;
         inflight_q   <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         mean_q       <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         rd_addr_q    <= rd_addr_d;
         tx_cnt_q     <= tx_cnt_d;
         sum_q        <= sum_d;
         mode_q       <= mode_d;
         inflight_q   <= inflight_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         mean_q       <= mean_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign state      = state_q;
   assign mean_out   = mean_q;
   assign frame_done = (state_q == ST_DONE);
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_threshold_buffer.sv
// Self-checking bench: table of frames replayed against a behavioural model.
module tb_frame_threshold_buffer;

   localparam int NPIX = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       valid_rx;
   logic [7:0] data_rx;
   logic [1:0] mode;
   logic       ready_tx;
   logic [7:0] data_out;
   logic       data_valid;
   logic [1:0] state;
   logic [7:0] mean_out;
   logic       frame_done;
   logic       overrun;

   frame_threshold_buffer #(
      .PIX_W  (8),
      .LOG2_W (2),
      .LOG2_H (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .valid_rx   (valid_rx),
      .data_rx    (data_rx),
      .mode       (mode),
      .ready_tx   (ready_tx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .state      (state),
      .mean_out   (mean_out),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit ovr_model = 1'b0;

   typedef struct {
      int       pat;       // 0 ramp, 1 all 0xFF, 2 random, 3 ramp offset 100
      logic [1:0] md;
      bit       rdy_rand;
      bit       inject;
      int       exp_mean;  // -1: take the model's mean
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic int model_f(input int p, input int mean, input logic [1:0] md);
      case (md)
         2'b00:   return p;
         2'b01:   return (p > mean) ? 255 : 0;
         2'b10:   return 255 - p;
         default: return (p > mean) ? 0 : 255;
      endcase
   endfunction

   task automatic run_frame(input int pat, input logic [1:0] md, input bit rdy_rand,
                            input bit inject, input int exp_mean);
      int pix[NPIX];
      int got[$];
      int sum = 0, mean_m, cyc = 0, read_seen = -1, first_dv = -1, hold_val = 0;
      bit done = 0, injected = 0, holding = 0;
      for (int i = 0; i < NPIX; i++) begin
         pix[i] = (pat == 0) ? i : (pat == 1) ? 255 : (pat == 3) ? 100 + i
                : int'($urandom_range(0, 255));
         sum += pix[i];
      end
      mean_m = (exp_mean >= 0) ? exp_mean : sum / NPIX;
      for (int i = 0; i < NPIX; i++) begin
         @(negedge clk);
         valid_rx = 1'b1;
         data_rx  = pix[i][7:0];
         mode     = md;
         ready_tx = 1'b1;
      end
      @(negedge clk);
      valid_rx = 1'b0;
      while (!done && cyc < 400) begin
         if (holding) begin
            check("hold_valid", int'(data_valid), 1);
            check("hold_data", int'(data_out), hold_val);
         end
         if (read_seen < 0 && state == 2'b10) read_seen = cyc;
         if (first_dv < 0 && data_valid) first_dv = cyc;
         if (frame_done) done = 1;
         ready_tx = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         valid_rx = 1'b0;
         if (inject && !injected && state == 2'b10 && got.size() == 5) begin
            valid_rx  = 1'b1;
            data_rx   = 8'hAA;
            injected  = 1;
            ovr_model = 1'b1;
         end
         if (!done && data_valid && ready_tx) got.push_back(int'(data_out));
         holding  = !done && data_valid && !ready_tx;
         hold_val = int'(data_out);
         @(negedge clk);
         cyc++;
      end
      valid_rx = 1'b0;
      if (!done) check("frame_done_timeout", 0, 1);
      if (!rdy_rand) check("first_valid_latency", first_dv - read_seen, 2);
      check("xfer_count", got.size(), NPIX);
      for (int i = 0; i < NPIX && i < got.size(); i++)
         check($sformatf("pixel[%0d] mode %0d", i, md), got[i], model_f(pix[i], mean_m, md));
      check("mean_out", int'(mean_out), mean_m);
      check("frame_done_pulse_width", int'(frame_done), 0);
      check("state_after_done", int'(state), 0);
      check("no_extra_valid", int'(data_valid), 0);
      check("overrun", int'(overrun), int'(ovr_model));
   endtask

   initial begin
      vecs[0] = '{pat: 0, md: 2'b00, rdy_rand: 0, inject: 0, exp_mean: 7};
      vecs[1] = '{pat: 0, md: 2'b01, rdy_rand: 0, inject: 0, exp_mean: 7};
      vecs[2] = '{pat: 0, md: 2'b11, rdy_rand: 0, inject: 0, exp_mean: 7};
      vecs[3] = '{pat: 0, md: 2'b00, rdy_rand: 1, inject: 0, exp_mean: 7};
      vecs[4] = '{pat: 1, md: 2'b01, rdy_rand: 0, inject: 0, exp_mean: 255};
      vecs[5] = '{pat: 1, md: 2'b10, rdy_rand: 0, inject: 0, exp_mean: 255};
      vecs[6] = '{pat: 0, md: 2'b00, rdy_rand: 0, inject: 1, exp_mean: 7};
      vecs[7] = '{pat: 2, md: 2'b01, rdy_rand: 0, inject: 0, exp_mean: -1};
      vecs[8] = '{pat: 2, md: 2'b10, rdy_rand: 1, inject: 0, exp_mean: -1};
      vecs[9] = '{pat: 3, md: 2'b11, rdy_rand: 1, inject: 1, exp_mean: 107};

      reset    = 1'b1;
      valid_rx = 1'b0;
      data_rx  = '0;
      mode     = 2'b00;
      ready_tx = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_state", int'(state), 0);
      check("reset_data_out", int'(data_out), 0);
      check("reset_data_valid", int'(data_valid), 0);
      check("reset_mean_out", int'(mean_out), 0);
      check("reset_frame_done", int'(frame_done), 0);
      check("reset_overrun", int'(overrun), 0);

      for (int v = 0; v < 10; v++)
         run_frame(vecs[v].pat, vecs[v].md, vecs[v].rdy_rand, vecs[v].inject, vecs[v].exp_mean);

      // Reset after a partial frame: stale sum or address must not survive.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         valid_rx = 1'b1;
         data_rx  = 8'(200 + i);
      end
      @(negedge clk);
      valid_rx = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      ovr_model = 1'b0;
      check("midreset_state", int'(state), 0);
      check("midreset_data_out", int'(data_out), 0);
      check("midreset_data_valid", int'(data_valid), 0);
      check("midreset_mean_out", int'(mean_out), 0);
      check("midreset_overrun", int'(overrun), 0);
      run_frame(0, 2'b00, 0, 0, 7);
      run_frame(0, 2'b01, 1, 0, 7);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/frame_threshold_buffer.md
Name: frame_threshold_buffer

Overview:
Parametrised successor to the single-frame UART image buffer. Captures one WxH frame of pixels arriving on the UART receive stream into an internal dual-port RAM and accumulates the pixel sum while it writes. At end of frame it computes the mean. It then streams the frame back to the UART transmitter in one of four pixel modes: passthrough, mean-threshold, invert, or inverted threshold.

Parameters:
PIX_W, 8, pixel width in bits (matches UART byte for default)
LOG2_W, 6, log2 of frame width in pixels
LOG2_H, 6, log2 of frame height in pixels
(derived, not overridable) N = 2**(LOG2_W+LOG2_H) pixels; AW = LOG2_W+LOG2_H; SUM_W = PIX_W+AW

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
valid_rx  in  1  one-cycle strobe: data_rx holds a received pixel
data_rx  in  PIX_W  received pixel
mode  in  2  pixel mode: 00 pass, 01 threshold, 10 invert, 11 inverted threshold
ready_tx  in  1  transmitter accepts data_out this cycle
data_out  out  PIX_W  output pixel
data_valid  out  1  data_out valid; transfer occurs when data_valid && ready_tx
state  out  2  current FSM state
mean_out  out  PIX_W  mean of the last captured frame
frame_done  out  1  one-cycle pulse after the last pixel transfer
overrun  out  1  sticky: pixel received outside WRITE and dropped

Behaviour:
- One clock (clk). Reset is synchronous, active-high. All registers update on posedge clk only.
- Reset values:
  - state=WRITE(00); wr_addr=0, rd_addr=0, tx_cnt=0, sum=0.
  - data_out=0, data_valid=0, mean_out=0, frame_done=0, overrun=0.
  - RAM contents are not cleared.
- FSM states: WRITE=00, CALC=01, READ=10, DONE=11.
- WRITE:
  - On each valid_rx: RAM[wr_addr]<=data_rx; wr_addr+=1; sum+=data_rx (SUM_W bits, cannot overflow).
  - On valid_rx with wr_addr==N-1: write the final pixel and go to CALC.
- CALC (exactly 1 cycle):
  - mean_out <= (sum incl. final pixel) >> AW, truncating.
  - Latch mode into mode_q; mode is ignored during READ.
  - Go to READ.
- READ:
  - At most one RAM read in flight. RAM read latency is 1 cycle.
  - Issue read RAM[rd_addr] when rd_addr<N, no read is in flight, and (!data_valid || ready_tx). rd_addr+=1 on issue.
  - On read return: data_out <= f(pixel) and data_valid<=1. data_out stays stable while data_valid && !ready_tx.
  - On a transfer with no return in the same cycle: data_valid<=0.
  - Each transfer: tx_cnt+=1. The transfer with tx_cnt==N-1 goes to DONE.
  - Throughput is at most 1 pixel per 2 cycles. From READ entry with ready_tx=1, the first data_valid appears 2 cycles later.
- f(p) by mode_q:
  - 00: p.
  - 01: (p > mean_out) ? all-ones : 0.
  - 10: ~p.
  - 11: (p > mean_out) ? 0 : all-ones.
  - Comparison is strict and unsigned.
- DONE (1 cycle):
  - frame_done=1, data_valid=0.
  - Clear wr_addr, rd_addr, tx_cnt, sum. Go to WRITE.
  - mean_out is held until the next CALC.
- Overrun: valid_rx in CALC, READ or DONE drops the byte (no RAM write, no sum change) and sets overrun=1. overrun clears only on reset.
- Reset mid-operation, in any state: all registers return to reset values and the next valid_rx is pixel 0 of a new frame. No partial output is resumed.
- ready_tx while data_valid=0 has no effect.

Decomposition:
- Package frame_threshold_pkg holds:
  - state encodings ST_WRITE, ST_CALC, ST_READ, ST_DONE;
  - mode encodings MODE_PASS, MODE_THR, MODE_INV, MODE_THR_INV;
  - a pixel-transform function f(p, mean, mode).
- One sub-module, frame_ram: simple dual-port RAM, depth N, width PIX_W. Write port: we/waddr/din. Read port: re/raddr/dout with 1-cycle registered output. Inferable as block RAM.

Test Plan:
All scenarios use LOG2_W=2, LOG2_H=2 (N=16), PIX_W=8.
1. Send pixels 0..15, mode=00, ready_tx=1 -> data_out 0..15 in order. mean_out=7 (sum 120>>4). Exactly 16 transfers, one frame_done pulse, state back to 00.
2. Same ramp, mode=01 -> pixels 0..7 output 0x00, pixels 8..15 output 0xFF. Same ramp, mode=11 -> the complement pattern.
3. Ramp with ready_tx randomly toggled -> data_out stable while data_valid && !ready_tx. Order 0..15 preserved, no duplicates or drops.
4. All pixels 0xFF -> sum=4080, mean_out=0xFF. mode=01 gives all 0x00 (strict compare); mode=10 gives all 0x00.
5. Pulse valid_rx with 0xAA during READ -> overrun=1, output stream unchanged, next frame captured correctly, overrun still 1.
6. Assert reset after 5 pixels in WRITE -> state=00, outputs at reset values. A new 16-pixel ramp yields mean_out=7 and correct output with no stale sum.
